// File: rtl/kbd_cmd_pkg.sv
// Shared scan codes, command opcodes and prefix-decoder states for the keyboard scheduler.
package kbd_cmd_pkg;

  localparam logic [7:0] KC_E0 = 8'hE0;
  localparam logic [7:0] KC_F0 = 8'hF0;

  localparam logic [7:0] KC_P1_UP    = 8'h1D;
  localparam logic [7:0] KC_P1_DOWN  = 8'h1B;
  localparam logic [7:0] KC_P1_LEFT  = 8'h1C;
  localparam logic [7:0] KC_P1_RIGHT = 8'h23;
  localparam logic [7:0] KC_P1_BOMB  = 8'h29;

  localparam logic [7:0] KC_P2_UP    = 8'h75;
  localparam logic [7:0] KC_P2_DOWN  = 8'h72;
  localparam logic [7:0] KC_P2_LEFT  = 8'h6B;
  localparam logic [7:0] KC_P2_RIGHT = 8'h74;
  localparam logic [7:0] KC_P2_BOMB  = 8'h5A;

  // Opcodes double as the bit index within a player's held_keys field.
  localparam logic [2:0] OP_UP    = 3'd0;
  localparam logic [2:0] OP_DOWN  = 3'd1;
  localparam logic [2:0] OP_LEFT  = 3'd2;
  localparam logic [2:0] OP_RIGHT = 3'd3;
  localparam logic [2:0] OP_BOMB  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } prefix_state_t;

  typedef struct packed {
    logic       hit;
    logic       player;
    logic [2:0] idx;
  } key_t;

  // Map a (possibly E0-extended) scan code to a player key.
  function automatic key_t decode_key(input logic ext, input logic [7:0] code);
    key_t k;
    k     = '0;
    k.hit = 1'b1;
    if (!ext) begin
      case (code)
        KC_P1_UP:    k.idx = OP_UP;
        KC_P1_DOWN:  k.idx = OP_DOWN;
        KC_P1_LEFT:  k.idx = OP_LEFT;
        KC_P1_RIGHT: k.idx = OP_RIGHT;
        KC_P1_BOMB:  k.idx = OP_BOMB;
        KC_P2_BOMB:  begin k.player = 1'b1; k.idx = OP_BOMB; end
        default:     k.hit = 1'b0;
      endcase
    end else begin
      k.player = 1'b1;
      case (code)
        KC_P2_UP:    k.idx = OP_UP;
        KC_P2_DOWN:  k.idx = OP_DOWN;
        KC_P2_LEFT:  k.idx = OP_LEFT;
        KC_P2_RIGHT: k.idx = OP_RIGHT;
        default:     k.hit = 1'b0;
      endcase
    end
    return k;
  endfunction

  // Highest-priority held direction: up > down > left > right.
  function automatic logic [1:0] prio_dir(input logic [3:0] dirs);
    if (dirs[0])      return 2'd0;
    else if (dirs[1]) return 2'd1;
    else if (dirs[2]) return 2'd2;
    else              return 2'd3;
  endfunction

endpackage

// File: rtl/kbd_repeat_timer.sv
// Per-player auto-repeat timer: first-delay then periodic fire pulses while a direction is held.
module kbd_repeat_timer #(
  parameter int unsigned FIRST_DELAY   = 12_500_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000,
  parameter int unsigned CNT_W         = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic active,
  input  logic enable_q,
  output logic fire
);

  logic [CNT_W-1:0] cnt;
  logic             expire;

  // A fresh make restarts the delay and suppresses a coincident expiry.
  assign expire = active && !restart && (cnt == CNT_W'(1));
  assign fire   = expire && enable_q;

  // Load, reload or count down; idle whenever no direction is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               cnt <= '0;
    else if (restart)        cnt <= CNT_W'(FIRST_DELAY);
    else if (!active)        cnt <= '0;
    else if (expire)         cnt <= CNT_W'(REPEAT_CYCLES);
    else if (cnt != '0)      cnt <= cnt - CNT_W'(1);
  end

endmodule

// File: rtl/kbd_cmd_scheduler.sv
// PS/2 byte decoder, held-key tracker and round-robin command scheduler for two players.
module kbd_cmd_scheduler
  import kbd_cmd_pkg::*;
#(
  parameter int unsigned FIRST_DELAY   = 12_500_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000,
  parameter int unsigned CNT_W         = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  input  logic       enable,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       cmd_player,
  output logic [2:0] cmd_op,
  output logic [9:0] held_keys
);

  prefix_state_t   state_q, state_d;
  logic            is_make, is_break, is_ext;
  key_t            key;
  logic [3:0]      key_pos;
  logic [9:0]      key_mask, held_d;
  logic            new_make;
  logic [1:0]      dir_make, bomb_make, active, fire;
  logic [1:0]      move_set, bomb_set, move_clr, bomb_clr;
  logic [1:0][1:0] dir_set, move_dir;
  logic [1:0]      move_pend, bomb_pend;
  logic            rr_ptr, load, any, sel, sel_bomb;
  logic [2:0]      sel_op;

  // Prefix state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Prefix next-state and make/break classification of the current byte.
  always_comb begin
    state_d  = state_q;
    is_make  = 1'b0;
    is_break = 1'b0;
    is_ext   = 1'b0;
    if (rx_done_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == KC_E0)      state_d = ST_EXT;
          else if (rx_data == KC_F0) state_d = ST_BRK;
          else                       is_make = 1'b1;
        end
        ST_EXT: begin
          if (rx_data == KC_F0) state_d = ST_EXT_BRK;
          else begin
            is_make = 1'b1;
            is_ext  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          is_break = 1'b1;
          state_d  = ST_IDLE;
        end
        ST_EXT_BRK: begin
          is_break = 1'b1;
          is_ext   = 1'b1;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Held-key update; a make on an already-held key is keyboard typematic and ignored.
  always_comb begin
    key      = decode_key(is_ext, rx_data);
    key_pos  = (key.player ? 4'd5 : 4'd0) + {1'b0, key.idx};
    key_mask = key.hit ? (10'd1 << key_pos) : '0;
    new_make = is_make && key.hit && ((held_keys & key_mask) == '0);
    held_d   = held_keys;
    if (new_make)              held_d = held_d | key_mask;
    if (is_break && key.hit)   held_d = held_d & ~key_mask;
    for (int unsigned p = 0; p < 2; p++) begin
      dir_make[p]  = new_make && (key.player == 1'(p)) && (key.idx != OP_BOMB);
      bomb_make[p] = new_make && (key.player == 1'(p)) && (key.idx == OP_BOMB);
      active[p]    = |held_d[p*5 +: 4];
    end
  end

  // Pending-slot set requests from fresh makes and timer expiries.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      dir_set[p]  = dir_make[p] ? key.idx[1:0] : prio_dir(held_d[p*5 +: 4]);
      move_set[p] = enable && (dir_make[p] || fire[p]);
      bomb_set[p] = enable && bomb_make[p];
    end
  end

  kbd_repeat_timer #(
    .FIRST_DELAY  (FIRST_DELAY),
    .REPEAT_CYCLES(REPEAT_CYCLES),
    .CNT_W        (CNT_W)
  ) u_timer_p1 (
    .clk     (clk),
    .reset   (reset),
    .restart (dir_make[0]),
    .active  (active[0]),
    .enable_q(enable),
    .fire    (fire[0])
  );

  kbd_repeat_timer #(
    .FIRST_DELAY  (FIRST_DELAY),
    .REPEAT_CYCLES(REPEAT_CYCLES),
    .CNT_W        (CNT_W)
  ) u_timer_p2 (
    .clk     (clk),
    .reset   (reset),
    .restart (dir_make[1]),
    .active  (active[1]),
    .enable_q(enable),
    .fire    (fire[1])
  );

  // Round-robin selection and grant clears; bomb goes before move within a player.
  always_comb begin
    load     = !cmd_valid || cmd_ready;
    any      = 1'b1;
    sel      = rr_ptr;
    move_clr = '0;
    bomb_clr = '0;
    if (move_pend[rr_ptr] || bomb_pend[rr_ptr])        sel = rr_ptr;
    else if (move_pend[~rr_ptr] || bomb_pend[~rr_ptr]) sel = ~rr_ptr;
    else                                               any = 1'b0;
    sel_bomb = bomb_pend[sel];
    sel_op   = sel_bomb ? OP_BOMB : {1'b0, move_dir[sel]};
    if (load && any) begin
      if (sel_bomb) bomb_clr[sel] = 1'b1;
      else          move_clr[sel] = 1'b1;
    end
  end

  // Held keys and pending slots; a set beats a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_keys <= '0;
      move_pend <= '0;
      bomb_pend <= '0;
      move_dir  <= '0;
    end else begin
      held_keys <= held_d;
      for (int unsigned p = 0; p < 2; p++) begin
        if (move_set[p]) begin
          move_pend[p] <= 1'b1;
          move_dir[p]  <= dir_set[p];
        end else if (!enable || move_clr[p]) begin
          move_pend[p] <= 1'b0;
        end
        if (bomb_set[p])                     bomb_pend[p] <= 1'b1;
        else if (!enable || bomb_clr[p])     bomb_pend[p] <= 1'b0;
      end
    end
  end

  // Output command register; holds steady while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_valid  <= 1'b0;
      cmd_player <= 1'b0;
      cmd_op     <= '0;
      rr_ptr     <= 1'b0;
    end else if (load) begin
      cmd_valid <= any;
      if (any) begin
        cmd_player <= sel;
        cmd_op     <= sel_op;
        rr_ptr     <= ~sel;
      end
    end
  end

endmodule
